// File: rtl/group_split.sv
// Splits one block-float group (shared exponent + SIZE signed mantissas) into SIZE
// independent floats, normalising one lane per cycle. Optional status port: GROUP_SPLIT_STATUS_EN.
module group_split #(
  parameter int SIZE            = 4,
  parameter int EXPONENT        = 8,
  parameter int FRACTION        = 9,
  parameter int SIGNED_MANTISSA = FRACTION + 2,
  parameter int WIDTH           = EXPONENT + FRACTION + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [EXPONENT-1:0]             exponent_in,
  input  logic [SIZE*SIGNED_MANTISSA-1:0] mantissas_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SIZE*WIDTH-1:0]           array_out
`ifdef GROUP_SPLIT_STATUS_EN
  ,
  output logic [2:0]                      status
`endif
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int LW = $clog2(SIGNED_MANTISSA);
  localparam int EW = EXPONENT + 2;
  localparam logic [EXPONENT-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [EXPONENT-1:0]             exp_q, exp_d;
  logic [SIZE*SIGNED_MANTISSA-1:0] mant_q, mant_d;
  logic [SIZE*WIDTH-1:0]           array_q, array_d;

  // Shared single-lane normalisation datapath
  logic [SIGNED_MANTISSA-1:0] lane_m, lane_mag;
  logic                       lane_s;
  logic [LW-1:0]              lead, shift;
  logic signed [EW-1:0]       exp_calc;
  logic [FRACTION-1:0]        lane_frac;
  logic                       lane_nan, lane_ovf, lane_unf;
  logic [WIDTH-1:0]           lane_result;

  always_comb begin
    lane_m   = mant_q[cnt_q*SIGNED_MANTISSA +: SIGNED_MANTISSA];
    lane_s   = lane_m[SIGNED_MANTISSA-1];
    lane_mag = lane_s ? (~lane_m + SIGNED_MANTISSA'(1)) : lane_m;
    lead     = '0;
    for (int i = 0; i < SIGNED_MANTISSA; i++) begin
      if (lane_mag[i]) lead = LW'(i);
    end
    // Extended width keeps the sign of exponents below zero and headroom above EXP_MAX.
    exp_calc  = EW'(exp_q) + EW'(lead) - EW'(FRACTION);
    shift     = LW'(FRACTION) - lead;
    lane_frac = (lead > LW'(FRACTION)) ? '0 : FRACTION'(lane_mag << shift);
    lane_nan  = (exp_q == EXP_MAX);
    lane_unf  = !lane_nan && (lane_mag != '0) && (exp_calc[EW-1] || (exp_calc == '0));
    lane_ovf  = !lane_nan && (lane_mag != '0) && !exp_calc[EW-1] &&
                (exp_calc >= EW'(EXP_MAX));

    lane_result = '0;
    if (lane_nan) begin
      lane_result[WIDTH-1]              = 1'b1;
      lane_result[WIDTH-2 -: EXPONENT]  = '1;
      lane_result[FRACTION-1]           = 1'b1;
    end else if (lane_mag == '0) begin
      lane_result = '0;
    end else if (lane_unf) begin
      lane_result[WIDTH-1] = lane_s;
    end else if (lane_ovf) begin
      lane_result[WIDTH-1]             = lane_s;
      lane_result[WIDTH-2 -: EXPONENT] = '1;
    end else begin
      lane_result = {lane_s, exp_calc[EXPONENT-1:0], lane_frac};
    end
  end

`ifdef GROUP_SPLIT_STATUS_EN
  logic [2:0] status_q, status_d;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    array_d = array_q;
`ifdef GROUP_SPLIT_STATUS_EN
    status_d = status_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_d   = exponent_in;
          mant_d  = mantissas_in;
          cnt_d   = '0;
          state_d = NORM;
`ifdef GROUP_SPLIT_STATUS_EN
          status_d = '0;
`endif
        end
      end
      NORM: begin
        array_d[cnt_q*WIDTH +: WIDTH] = lane_result;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SIZE-1)) state_d = DONE;
`ifdef GROUP_SPLIT_STATUS_EN
        status_d = status_q | {lane_nan, lane_ovf, lane_unf};
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      mant_q  <= '0;
      array_q <= '0;
`ifdef GROUP_SPLIT_STATUS_EN
      status_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      array_q <= array_d;
`ifdef GROUP_SPLIT_STATUS_EN
      status_q <= status_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign array_out = array_q;
`ifdef GROUP_SPLIT_STATUS_EN
  assign status = status_q;
`endif

endmodule

// File: tb/tb_group_split.sv
// Scoreboard bench for group_split: expected groups are queued when driven and
// checked when out_valid appears. Status checks enabled by GROUP_SPLIT_STATUS_EN.
module tb_group_split;

  typedef struct packed {
    logic [71:0] arr;
    logic [2:0]  st;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  exponent_in;
  logic [43:0] mantissas_in;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] array_out;
`ifdef GROUP_SPLIT_STATUS_EN
  logic [2:0]  status;
`endif

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  exp_t sb[$];

  group_split dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .exponent_in  (exponent_in),
    .mantissas_in (mantissas_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .array_out    (array_out)
`ifdef GROUP_SPLIT_STATUS_EN
    ,
    .status       (status)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [43:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {11'(l3), 11'(l2), 11'(l1), 11'(l0)};
  endfunction

  // Reference: shift the magnitude up until bit 10 is set, tracking the exponent.
  function automatic exp_t model(input logic [7:0] e, input logic [43:0] m);
    exp_t r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      logic [10:0] lm;
      logic [17:0] f;
      logic        s;
      int          v, mag, ex, fr;
      lm  = m[i*11 +: 11];
      v   = int'($signed(lm));
      s   = lm[10];
      mag = (v < 0) ? -v : v;
      if (e == 8'hFF) begin
        f = 18'h3FF00;
        r.st[2] = 1'b1;
      end else if (mag == 0) begin
        f = '0;
      end else begin
        ex = int'(e);
        while (mag < 1024) begin
          mag = mag * 2;
          ex  = ex - 1;
        end
        ex = ex + 1;
        fr = (mag / 2) % 512;
        if (ex <= 0) begin
          f = {s, 17'h0};
          r.st[0] = 1'b1;
        end else if (ex >= 255) begin
          f = {s, 8'hFF, 9'h0};
          r.st[1] = 1'b1;
        end else begin
          f = {s, 8'(ex), 9'(fr)};
        end
      end
      r.arr[i*18 +: 18] = f;
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] e, input logic [43:0] m, output int acc);
    int n = 0;
    sb.push_back(model(e, m));
    in_valid     = 1'b1;
    exponent_in  = e;
    mantissas_in = m;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic receive(output int seen);
    exp_t ex;
    int   n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    seen = cyc;
    compared++;
    if (!out_valid) begin
      mismatched++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
    end else if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL scoreboard_empty: out_valid=1 with no expected group");
    end else begin
      ex = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (array_out[i*18 +: 18] !== ex.arr[i*18 +: 18]) begin
          mismatched++;
          $display("FAIL lane%0d: got %05h required %05h", i, array_out[i*18 +: 18],
                   ex.arr[i*18 +: 18]);
        end
      end
`ifdef GROUP_SPLIT_STATUS_EN
      compared++;
      if (status !== ex.st) begin
        mismatched++;
        $display("FAIL status: got %b required %b", status, ex.st);
      end
`endif
    end
    if (out_valid && out_ready) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_in_ready: got %b required 1", tag, in_ready);
    end
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_out_valid: got %b required 0", tag, out_valid);
    end
    compared++;
    if (array_out !== 72'h0) begin
      mismatched++;
      $display("FAIL %s_array_out: got %h required 0", tag, array_out);
    end
`ifdef GROUP_SPLIT_STATUS_EN
    compared++;
    if (status !== 3'b000) begin
      mismatched++;
      $display("FAIL %s_status: got %b required 000", tag, status);
    end
`endif
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int acc, seen;
    send(8'h80, pack(512, -512, 0, 1), acc);
    receive(seen);
    compared++;
    if (seen - acc !== 5) begin
      mismatched++;
      $display("FAIL latency: got %0d cycles required 5", seen - acc);
    end
  endtask

  task automatic test_neg_full;
    int acc, seen;
    send(8'h80, pack(-1024, 0, 0, 0), acc);
    receive(seen);
  endtask

  task automatic test_underflow;
    int acc, seen;
    send(8'h05, pack(1, 512, -2, 256), acc);
    receive(seen);
  endtask

  task automatic test_overflow_nan;
    int acc, seen;
    send(8'hFE, pack(-1024, 1023, 1, 0), acc);
    receive(seen);
    send(8'hFF, pack(0, 5, -7, 300), acc);
    receive(seen);
  endtask

  task automatic test_backpressure;
    int          acc, seen, n, hs;
    logic [71:0] snap;
    out_ready = 1'b0;
    send(8'h90, pack(100, -200, 300, -400), acc);
    receive(seen);
    snap = array_out;
    sb.push_back(model(8'h40, pack(-1, 2, -3, 1023)));
    in_valid     = 1'b1;
    exponent_in  = 8'h40;
    mantissas_in = pack(-1, 2, -3, 1023);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b1 || array_out !== snap || in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b array_out=%h required 1/0/%h",
                 k, out_valid, in_ready, array_out, snap);
      end
    end
    out_ready = 1'b1;
    hs = cyc;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL in_ready_after_handshake: got %b required 1", in_ready);
    end
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    receive(seen);
    compared++;
    if (acc - hs !== 1 || seen - acc !== 5) begin
      mismatched++;
      $display("FAIL second_accept: accept after %0d latency %0d required 1 and 5",
               acc - hs, seen - acc);
    end
  endtask

  task automatic test_reset_mid_norm;
    int   acc, seen;
    exp_t dropped;
    send(8'h80, pack(512, 1, 2, 3), acc);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_norm");
    reset   = 1'b0;
    dropped = sb.pop_back();
    @(negedge clk);
    send(8'h7F, pack(-3, 64, -1024, 17), acc);
    receive(seen);
  endtask

  task automatic test_back_to_back;
    int acc_t[4];
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int          a;
          logic [7:0]  e;
          logic [43:0] m;
          e = (i == 2) ? 8'hFF : 8'($urandom_range(1, 254));
          m = 44'({$urandom(), $urandom()});
          send(e, m, a);
          acc_t[i] = a;
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          int s;
          receive(s);
        end
      end
    join
    for (int i = 1; i < 4; i++) begin
      compared++;
      if (acc_t[i] - acc_t[i-1] !== 6) begin
        mismatched++;
        $display("FAIL throughput%0d: got %0d cycles required 6", i, acc_t[i] - acc_t[i-1]);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    exponent_in  = '0;
    mantissas_in = '0;
    out_ready    = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_neg_full();
    test_underflow();
    test_overflow_nan();
    test_backpressure();
    test_reset_mid_norm();
    test_back_to_back();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_leftover: got %0d groups required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
